// File: rtl/qam_pkg.sv
// Shared 16-QAM definitions: levels, widths, default rates and the carrier table
// used by both the signal generator and the coherent demodulator.
package qam_pkg;

  localparam int SIG_W  = 19;
  localparam int IQ_W   = 4;
  localparam int LUT_W  = 16;
  localparam int SPS    = 64;
  localparam int ACC_W  = 41;
  localparam longint THRESH = 64'sd34358689792;

  localparam logic signed [IQ_W-1:0] LVL_P3 = 4'sd3;
  localparam logic signed [IQ_W-1:0] LVL_P1 = 4'sd1;
  localparam logic signed [IQ_W-1:0] LVL_M1 = -4'sd1;
  localparam logic signed [IQ_W-1:0] LVL_M3 = -4'sd3;

  typedef enum logic {HUNT, INTEG} demod_state_t;

  // Quarter-wave sine, 64 points per period, amplitude 32767; the rest is mirrored.
  localparam int TBL_LEN = 64;
  localparam int QTR_LEN = TBL_LEN / 4;
  localparam int QTR [0:16] = '{0, 3212, 6393, 9512, 12539, 15446, 18204, 20787,
                                23170, 25329, 27245, 28898, 30273, 31356, 32137,
                                32609, 32767};

  function automatic int carrier_sin(input int k);
    int m;
    m = k % TBL_LEN;
    if (m <= QTR_LEN)          return QTR[m];
    else if (m <= 2 * QTR_LEN) return QTR[2 * QTR_LEN - m];
    else if (m <= 3 * QTR_LEN) return -QTR[m - 2 * QTR_LEN];
    else                       return -QTR[TBL_LEN - m];
  endfunction

  function automatic int carrier_cos(input int k);
    return carrier_sin(k + QTR_LEN);
  endfunction

  function automatic logic signed [IQ_W-1:0] slice_level(input longint acc, input longint thresh);
    if (acc >= thresh)       return LVL_P3;
    else if (acc >= 0)       return LVL_P1;
    else if (acc >= -thresh) return LVL_M1;
    else                     return LVL_M3;
  endfunction

endpackage

// File: rtl/qam_coherent_demod_if.sv
// Sample stream in, recovered constellation points out; the generator side
// uses master, the demodulator uses slave.
interface qam_coherent_demod_if;
  import qam_pkg::*;

  logic signed [SIG_W-1:0] signal;
  logic                    sample_valid;
  logic                    sym_sync;
  logic signed [IQ_W-1:0]  i;
  logic signed [IQ_W-1:0]  q;
  logic                    out_valid;
  logic                    sync_err;

  modport master (
    output signal, sample_valid, sym_sync,
    input  i, q, out_valid, sync_err
  );

  modport slave (
    input  signal, sample_valid, sym_sync,
    output i, q, out_valid, sync_err
  );

endinterface

// File: rtl/qam_carrier_rom.sv
// Synchronous quadrature carrier ROM, one read per cycle, one cycle latency.
// Entries come from the shared table so transmitter and receiver phases match.
module qam_carrier_rom #(
  parameter int SPS   = qam_pkg::SPS,
  parameter int LUT_W = qam_pkg::LUT_W
) (
  input  logic                     clk,
  input  logic [$clog2(SPS)-1:0]   addr,
  output logic signed [LUT_W-1:0]  cos_q,
  output logic signed [LUT_W-1:0]  sin_q
);
  import qam_pkg::*;

  localparam int STEP = TBL_LEN / SPS;

  always_ff @(posedge clk) begin
    cos_q <= LUT_W'(carrier_cos(int'(addr) * STEP));
    sin_q <= LUT_W'(carrier_sin(int'(addr) * STEP));
  end

endmodule

// File: rtl/qam_coherent_demod.sv
// Coherent 16-QAM demodulator: mix with local carrier, integrate-and-dump per
// symbol, slice to {-3,-1,1,3}. Four-edge pipeline from last sample to i/q.
module qam_coherent_demod #(
  parameter int     SPS    = qam_pkg::SPS,
  parameter int     LUT_W  = qam_pkg::LUT_W,
  parameter int     ACC_W  = qam_pkg::ACC_W,
  parameter longint THRESH = qam_pkg::THRESH
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  qam_coherent_demod_if.slave  bus
);
  import qam_pkg::*;

  localparam int PH_W   = $clog2(SPS);
  localparam int PROD_W = SIG_W + LUT_W;

  demod_state_t state;
  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] eff_ph;
  logic            accept;
  logic            resync;

  logic signed [LUT_W-1:0]  cos_s1, sin_s1;
  logic signed [SIG_W-1:0]  sig_s1;
  logic                     v_s1, first_s1, last_s1;
  logic signed [PROD_W-1:0] p_i, p_q;
  logic                     v_s2, first_s2, last_s2;
  logic signed [ACC_W-1:0]  acc_i, acc_q;
  logic                     dump_s3;
  logic signed [ACC_W-1:0]  dump_i, dump_q;
  logic                     dump_v;

  // A sym_sync sample always sits at phase 0; a sync anywhere else abandons the partial symbol.
  always_comb begin
    accept = bus.sample_valid && (state == INTEG || bus.sym_sync);
    eff_ph = bus.sym_sync ? '0 : ph;
    resync = accept && bus.sym_sync && (state == INTEG) && (ph != '0);
  end

  qam_carrier_rom #(
    .SPS   (SPS),
    .LUT_W (LUT_W)
  ) u_rom (
    .clk   (CLOCK_50),
    .addr  (eff_ph),
    .cos_q (cos_s1),
    .sin_q (sin_s1)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state        <= HUNT;
      ph           <= '0;
      bus.sync_err <= 1'b0;
    end else begin
      bus.sync_err <= resync;
      if (accept) begin
        state <= INTEG;
        ph    <= eff_ph + PH_W'(1);
      end
    end
  end

  // Bubbles flow through with valid low, so latency is fixed and gaps cost nothing.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sig_s1        <= '0;
      v_s1          <= 1'b0;
      first_s1      <= 1'b0;
      last_s1       <= 1'b0;
      p_i           <= '0;
      p_q           <= '0;
      v_s2          <= 1'b0;
      first_s2      <= 1'b0;
      last_s2       <= 1'b0;
      acc_i         <= '0;
      acc_q         <= '0;
      dump_s3       <= 1'b0;
      dump_i        <= '0;
      dump_q        <= '0;
      dump_v        <= 1'b0;
      bus.i         <= '0;
      bus.q         <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      sig_s1   <= bus.signal;
      v_s1     <= accept;
      first_s1 <= accept && (eff_ph == '0);
      last_s1  <= accept && (eff_ph == PH_W'(SPS - 1));

      v_s2     <= v_s1;
      first_s2 <= first_s1;
      last_s2  <= last_s1;
      p_i      <= PROD_W'(sig_s1) * PROD_W'(cos_s1);
      p_q      <= PROD_W'(sig_s1) * PROD_W'(sin_s1);

      if (v_s2) begin
        acc_i <= first_s2 ? ACC_W'(p_i) : acc_i + ACC_W'(p_i);
        acc_q <= first_s2 ? ACC_W'(p_q) : acc_q + ACC_W'(p_q);
      end
      dump_s3 <= v_s2 && last_s2;

      // The next symbol's first product may reload acc on this same edge; the dump still sees the old sum.
      dump_v <= dump_s3;
      if (dump_s3) begin
        dump_i <= acc_i;
        dump_q <= acc_q;
      end

      bus.out_valid <= dump_v;
      if (dump_v) begin
        bus.i <= slice_level(64'(dump_i), THRESH);
        bus.q <= slice_level(64'(dump_q), THRESH);
      end
    end
  end

endmodule

// File: tb/tb_qam_coherent_demod.sv
// Bench for qam_coherent_demod: ideal 16-QAM symbols generated from real-valued
// carrier math, recovered points checked through a cycle-stamped scoreboard.
module tb_qam_coherent_demod;

  localparam int     NSPS  = 64;
  localparam real    PI    = 3.141592653589793;
  localparam longint THR   = 64'sd34358689792;

  typedef struct {
    logic signed [3:0] i;
    logic signed [3:0] q;
    longint            cyc;
  } exp_t;

  typedef struct {
    int                sym_i;
    int                sym_q;
    logic signed [3:0] exp_i;
    logic signed [3:0] exp_q;
  } vec_t;

  typedef struct {
    longint            acc;
    logic signed [3:0] exp_lvl;
  } slc_t;

  logic   CLOCK_50 = 1'b0;
  logic   RESET_N;
  longint cyc = 0;
  int     compared = 0;
  int     mismatched = 0;
  int     pulses = 0;
  int     sync_errs = 0;
  exp_t   exp_q[$];
  longint exp_sync_q[$];

  qam_coherent_demod_if bus ();

  qam_coherent_demod dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endfunction

  function automatic logic signed [18:0] genSample(input int si, input int sq, input int k);
    real ang, r;
    ang = 2.0 * PI * real'(k) / real'(NSPS);
    r = 16384.0 * (real'(si) * $cos(ang) + real'(sq) * $sin(ang));
    if (r >= 0.0) return 19'($rtoi(r + 0.5));
    else          return 19'(-$rtoi(-r + 0.5));
  endfunction

  // Inputs change 1 time unit after a rising edge and are held through the next one.
  task automatic applyStimulus(input logic signed [18:0] s, input logic v, input logic sync);
    bus.signal       = s;
    bus.sample_valid = v;
    bus.sym_sync     = sync;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic sendSymbol(input int si, input int sq, input int gap_max, input int n_samp,
                            input bit expect_err);
    for (int k = 0; k < n_samp; k++) begin
      if (gap_max > 0) begin
        int g = $urandom_range(gap_max);
        repeat (g) applyStimulus(19'($urandom), 1'b0, 1'($urandom));
      end
      applyStimulus(genSample(si, sq, k), 1'b1, k == 0);
      if (k == 0 && expect_err) exp_sync_q.push_back(cyc);
      if (k == NSPS - 1) exp_q.push_back('{4'(si), 4'(sq), cyc + 4});
    end
  endtask

  task automatic drainCheck(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_sync_q.size() != 0) && n < 20) begin
      applyStimulus('0, 1'b0, 1'b0);
      n++;
    end
    repeat (8) applyStimulus('0, 1'b0, 1'b0);
    checkOutput({name, "_pending"}, longint'(exp_q.size() + exp_sync_q.size()), 0);
  endtask

  // Scoreboard: every out_valid / sync_err pulse must match a queued expectation and cycle.
  always @(negedge CLOCK_50) begin
    if (bus.out_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out_valid", longint'(bus.out_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("i", longint'(bus.i), longint'(e.i));
        checkOutput("q", longint'(bus.q), longint'(e.q));
        checkOutput("out_cycle", cyc, e.cyc);
      end
    end
    if (bus.sync_err === 1'b1) begin
      sync_errs++;
      if (exp_sync_q.size() == 0) checkOutput("spurious_sync_err", longint'(bus.sync_err), 0);
      else                        checkOutput("sync_err_cycle", cyc, exp_sync_q.pop_front());
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[16];
    slc_t slc[6];
    int   lvl[4] = '{-3, -1, 1, 3};
    int   p0, e0;

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        vecs[a * 4 + b] = '{lvl[a], lvl[b], 4'(lvl[a]), 4'(lvl[b])};
    slc[0] = '{THR,       4'sd3};
    slc[1] = '{THR - 1,   4'sd1};
    slc[2] = '{0,         4'sd1};
    slc[3] = '{-1,        -4'sd1};
    slc[4] = '{-THR,      -4'sd1};
    slc[5] = '{-THR - 1,  -4'sd3};

    RESET_N          = 1'b0;
    bus.signal       = '0;
    bus.sample_valid = 1'b0;
    bus.sym_sync     = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("reset_i", longint'(bus.i), 0);
    checkOutput("reset_q", longint'(bus.q), 0);
    checkOutput("reset_out_valid", longint'(bus.out_valid), 0);
    checkOutput("reset_sync_err", longint'(bus.sync_err), 0);
    RESET_N = 1'b1;
    applyStimulus('0, 1'b0, 1'b0);

    $display("[TB] single ideal symbol I=3 Q=-1");
    p0 = pulses;
    sendSymbol(3, -1, 0, NSPS, 0);
    drainCheck("single");
    checkOutput("single_pulses", pulses - p0, 1);
    checkOutput("single_hold_i", longint'(bus.i), 3);
    checkOutput("single_hold_q", longint'(bus.q), -1);

    $display("[TB] 16 symbols back to back");
    p0 = pulses;
    for (int k = 0; k < 16; k++) sendSymbol(vecs[k].sym_i, vecs[k].sym_q, 0, NSPS, 0);
    drainCheck("b2b");
    checkOutput("b2b_pulses", pulses - p0, 16);

    $display("[TB] 16 symbols with random gaps");
    p0 = pulses;
    for (int k = 15; k >= 0; k--) sendSymbol(vecs[k].sym_i, vecs[k].sym_q, 5, NSPS, 0);
    drainCheck("gaps");
    checkOutput("gaps_pulses", pulses - p0, 16);
    checkOutput("gaps_last_i", longint'(bus.i), longint'(vecs[0].exp_i));
    checkOutput("gaps_last_q", longint'(bus.q), longint'(vecs[0].exp_q));

    $display("[TB] resync at ph=20");
    p0 = pulses;
    e0 = sync_errs;
    sendSymbol(1, 3, 0, 20, 0);
    sendSymbol(-3, 1, 0, NSPS, 1);
    drainCheck("resync");
    checkOutput("resync_pulses", pulses - p0, 1);
    checkOutput("resync_errs", sync_errs - e0, 1);

    $display("[TB] reset at ph=30");
    sendSymbol(3, 3, 0, 30, 0);
    RESET_N          = 1'b0;
    bus.signal       = genSample(3, 3, 30);
    bus.sample_valid = 1'b1;
    bus.sym_sync     = 1'b0;
    @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    checkOutput("rst_mid_i", longint'(bus.i), 0);
    checkOutput("rst_mid_q", longint'(bus.q), 0);
    p0 = pulses;
    repeat (3) applyStimulus(19'($urandom), 1'b0, 1'b1);
    for (int k = 31; k < NSPS + 10; k++) applyStimulus(genSample(3, 3, k), 1'b1, 1'b0);
    repeat (8) applyStimulus('0, 1'b0, 1'b0);
    checkOutput("rst_hunt_pulses", pulses - p0, 0);
    sendSymbol(-1, -3, 0, NSPS, 0);
    drainCheck("rst_after");
    checkOutput("rst_after_pulses", pulses - p0, 1);

    $display("[TB] slicer boundaries");
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("slice_%0d", k), longint'(qam_pkg::slice_level(slc[k].acc, THR)),
                  longint'(slc[k].exp_lvl));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
